// File: rtl/pass_attempt_ctrl_if.sv
// Password handshake bundle: the requester presents pass/pass_valid and the
// controller answers with pass_ready.
interface pass_attempt_ctrl_if;
  logic [1:0] pass;
  logic       pass_valid;
  logic       pass_ready;

  modport master (
    output pass,
    output pass_valid,
    input  pass_ready
  );

  modport slave (
    input  pass,
    input  pass_valid,
    output pass_ready
  );
endinterface

// File: rtl/pass_attempt_ctrl.sv
// Password attempt controller: checks a 2-bit password against a stored key,
// opens the door on a match and locks out after MAX_FAIL consecutive misses.
module pass_attempt_ctrl #(
  parameter logic [1:0]  KEY_INIT    = 2'b10,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pass_attempt_ctrl_if.slave  pif,
  input  logic                key_wr,
  input  logic [1:0]          key_in,
  output logic                door_open,
  output logic                err,
  output logic                locked,
  output logic                alarm,
  output logic [1:0]          fail_cnt
);

  localparam logic [2:0] MaxFailW = 3'(MAX_FAIL);
  // Windows count down to zero, so load one less than the length.
  localparam logic [7:0] OpenLoad = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] LockLoad = 8'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StOpen,
    StFail,
    StLocked
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] pass_q, pass_d;
  logic [1:0] key_q, key_d;
  logic [1:0] fail_cnt_q, fail_cnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] fail_inc;

  logic pass_ready_q, door_open_q, err_q, locked_q, alarm_q;

  assign fail_inc = {1'b0, fail_cnt_q} + 3'd1;

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    key_d      = key_q;
    fail_cnt_d = fail_cnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pif.pass_valid) begin
          pass_d  = pif.pass;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (pass_q == key_q) begin
          fail_cnt_d = 2'd0;
          cnt_d      = OpenLoad;
          state_d    = StOpen;
        end else if (fail_inc < MaxFailW) begin
          fail_cnt_d = fail_inc[1:0];
          state_d    = StFail;
        end else begin
          fail_cnt_d = MaxFailW[1:0];
          cnt_d      = LockLoad;
          state_d    = StLocked;
        end
      end
      StFail: begin
        state_d = StIdle;
      end
      StOpen: begin
        // Key writes only inside an authorised session; window length is unaffected.
        if (key_wr) key_d = key_in;
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StLocked: begin
        if (cnt_q == 8'd0) begin
          fail_cnt_d = 2'd0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pass_q       <= 2'b00;
      key_q        <= KEY_INIT;
      fail_cnt_q   <= 2'd0;
      cnt_q        <= 8'd0;
      pass_ready_q <= 1'b1;
      door_open_q  <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      key_q        <= key_d;
      fail_cnt_q   <= fail_cnt_d;
      cnt_q        <= cnt_d;
      pass_ready_q <= (state_d == StIdle);
      door_open_q  <= (state_d == StOpen);
      err_q        <= (state_d == StFail);
      locked_q     <= (state_d == StLocked);
      alarm_q      <= (state_d == StLocked);
    end
  end

  assign pif.pass_ready = pass_ready_q;
  assign door_open      = door_open_q;
  assign err            = err_q;
  assign locked         = locked_q;
  assign alarm          = alarm_q;
  assign fail_cnt       = fail_cnt_q;

endmodule

// File: tb/tb_pass_attempt_ctrl.sv
// Self-checking bench for pass_attempt_ctrl: an attempt-level model predicts
// the per-cycle output trace of each password attempt.
module tb_pass_attempt_ctrl;

  localparam logic [1:0]  KeyInit    = 2'b10;
  localparam int unsigned MaxFail    = 3;
  localparam int unsigned OpenCycles = 8;
  localparam int unsigned LockCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_wr;
  logic [1:0] key_in;
  logic       door_open, err, locked, alarm;
  logic [1:0] fail_cnt;

  pass_attempt_ctrl_if pif ();

  pass_attempt_ctrl #(
    .KEY_INIT    (KeyInit),
    .MAX_FAIL    (MaxFail),
    .OPEN_CYCLES (OpenCycles),
    .LOCK_CYCLES (LockCycles)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pif       (pif),
    .key_wr    (key_wr),
    .key_in    (key_in),
    .door_open (door_open),
    .err       (err),
    .locked    (locked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  // Trace word: {pass_ready, door_open, err, locked, alarm, fail_cnt[1:0]}
  typedef logic [6:0] obs_t;

  int         errors = 0;
  int         checks = 0;
  logic [1:0] m_key;
  int         m_fails;
  obs_t       exp_q[$];
  obs_t       obs_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t snap();
    return {pif.pass_ready, door_open, err, locked, alarm, fail_cnt};
  endfunction

  function automatic obs_t mk(bit r, bit d, bit e, bit l, bit a, int f);
    return {r, d, e, l, a, 2'(f)};
  endfunction

  // Expected trace of one attempt: the check cycle, the outcome window, then idle.
  function automatic void model(input logic [1:0] p, input int wr_at, input logic [1:0] wr_key);
    exp_q.push_back(mk(0, 0, 0, 0, 0, m_fails));
    if (p == m_key) begin
      m_fails = 0;
      repeat (OpenCycles) exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
      if (wr_at >= 0) m_key = wr_key;
    end else if (m_fails + 1 < MaxFail) begin
      m_fails++;
      exp_q.push_back(mk(0, 0, 1, 0, 0, m_fails));
    end else begin
      repeat (LockCycles) exp_q.push_back(mk(0, 0, 0, 1, 1, MaxFail));
      m_fails = 0;
    end
    exp_q.push_back(mk(1, 0, 0, 0, 0, m_fails));
  endfunction

  // Drives one attempt and records observed outputs for the trace just modelled.
  // With noise, pass_valid/key_wr toggle randomly wherever they must be ignored.
  task automatic drive_attempt(input logic [1:0] p, input bit noise, input int wr_at,
                               input logic [1:0] wr_key);
    int start;
    bit last;
    start = obs_q.size();
    pif.pass       = p;
    pif.pass_valid = 1'b1;
    key_wr         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    key_in         = 2'($urandom);
    step();
    for (int i = start; i < exp_q.size(); i++) begin
      obs_q.push_back(snap());
      last           = (i == exp_q.size() - 1);
      pif.pass_valid = (noise && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
      pif.pass       = 2'($urandom);
      if (exp_q[i][5] && (i - start - 1) == wr_at) begin
        key_wr = 1'b1;
        key_in = wr_key;
      end else begin
        key_wr = (noise && !last && !exp_q[i][5]) ? 1'($urandom_range(0, 1)) : 1'b0;
        key_in = 2'($urandom);
      end
      if (!last) step();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_async: got %b required %b", snap(), mk(1, 0, 0, 0, 0, 0));
    end
    step();
    step();
    rst_n = 1'b1;
    m_key = KeyInit;
    m_fails = 0;
    checks++;
    if (snap() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", snap(), mk(1, 0, 0, 0, 0, 0));
    end
    // Attempt launched immediately so the handshake lands on the first edge after release.
    exp_q.delete();
    obs_q.delete();
    model(2'b10, -1, 2'b00);
    drive_attempt(2'b10, 1'b0, -1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL correct_pass cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrong_pass();
    exp_q.delete();
    obs_q.delete();
    model(2'b01, -1, 2'b00);
    drive_attempt(2'b01, 1'b0, -1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrong_pass cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lockout();
    logic [1:0] bad;
    exp_q.delete();
    obs_q.delete();
    model(m_key, -1, 2'b00);
    drive_attempt(m_key, 1'b0, -1, 2'b00);
    bad = ~m_key;
    for (int n = 0; n < 3; n++) begin
      model(bad, -1, 2'b00);
      drive_attempt(bad, 1'b1, -1, 2'b00);
    end
    model(m_key, -1, 2'b00);
    drive_attempt(m_key, 1'b0, -1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lockout cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fail_clear();
    logic [1:0] seq [4];
    seq[0] = 2'b00;
    seq[1] = 2'b11;
    seq[2] = m_key;
    seq[3] = 2'b01;
    exp_q.delete();
    obs_q.delete();
    for (int n = 0; n < 4; n++) begin
      model(seq[n], -1, 2'b00);
      drive_attempt(seq[n], 1'b0, -1, 2'b00);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fail_clear cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_key_change();
    exp_q.delete();
    obs_q.delete();
    model(2'b10, 3, 2'b11);
    drive_attempt(2'b10, 1'b0, 3, 2'b11);
    model(2'b10, -1, 2'b00);
    drive_attempt(2'b10, 1'b0, -1, 2'b00);
    model(2'b11, -1, 2'b00);
    drive_attempt(2'b11, 1'b0, -1, 2'b00);
    // key_wr while idle must not touch the stored key.
    key_wr = 1'b1;
    key_in = 2'b00;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (pif.pass_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_key_wr_ready: got %b required 1", pif.pass_ready);
      end
    end
    key_wr = 1'b0;
    model(2'b11, -1, 2'b00);
    drive_attempt(2'b11, 1'b0, -1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL key_change cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_open();
    pif.pass       = m_key;
    pif.pass_valid = 1'b1;
    step();
    pif.pass_valid = 1'b0;
    step();
    key_wr = 1'b1;
    key_in = 2'b01;
    step();
    key_wr = 1'b0;
    step();
    step();
    checks++;
    if (door_open !== 1'b1) begin
      errors++;
      $display("FAIL mid_open_door: got %b required 1", door_open);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_open_reset: got %b required %b", snap(), mk(1, 0, 0, 0, 0, 0));
    end
    step();
    rst_n = 1'b1;
    m_key = KeyInit;
    m_fails = 0;
    exp_q.delete();
    obs_q.delete();
    model(2'b01, -1, 2'b00);
    drive_attempt(2'b01, 1'b0, -1, 2'b00);
    model(2'b10, -1, 2'b00);
    drive_attempt(2'b10, 1'b0, -1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL after_reset cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [1:0] p;
    logic [1:0] k;
    int         wr_at;
    exp_q.delete();
    obs_q.delete();
    for (int n = 0; n < 40; n++) begin
      p     = 2'($urandom_range(0, 3));
      k     = 2'($urandom_range(0, 3));
      wr_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, OpenCycles - 1));
      model(p, wr_at, k);
      drive_attempt(p, 1'b1, wr_at, k);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    pif.pass       = 2'b00;
    pif.pass_valid = 1'b0;
    key_wr         = 1'b0;
    key_in         = 2'b00;
    m_key          = KeyInit;
    m_fails        = 0;
    test_reset();
    test_wrong_pass();
    test_lockout();
    test_fail_clear();
    test_key_change();
    test_reset_mid_open();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pass_attempt_ctrl.md
PASS_ATTEMPT_CTRL -- requirements
Module: pass_attempt_ctrl

Interface
REQ-001 Parameter KEY_INIT, default 2'b10: stored-key value loaded at reset.
REQ-002 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout; legal range 1..3.
REQ-003 Parameter OPEN_CYCLES, default 8: door_open pulse length in clocks; legal range 1..255.
REQ-004 Parameter LOCK_CYCLES, default 16: lockout length in clocks; legal range 1..255.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-006 pass  input  2  user-entered password.
REQ-007 pass_valid  input  1  pass is presented this cycle.
REQ-008 pass_ready  output  1  controller can accept a password.
REQ-009 key_wr  input  1  request to overwrite the stored key with key_in.
REQ-010 key_in  input  2  new key value.
REQ-011 door_open  output  1  unlock drive.
REQ-012 err  output  1  one-cycle wrong-password pulse.
REQ-013 locked  output  1  lockout in progress.
REQ-014 alarm  output  1  asserted for the whole lockout.
REQ-015 fail_cnt  output  2  current consecutive-failure count.

Function
REQ-016 FSM states: IDLE, CHECK, OPEN, FAIL, LOCKED. All outputs are registered or decoded from state only, with no combinational path from inputs.
REQ-017 IDLE: pass_ready=1. A handshake occurs when pass_valid && pass_ready; pass is captured into pass_q and the FSM goes to CHECK.
REQ-018 Outside IDLE: pass_ready=0. pass_valid is ignored with no side effect; nothing is queued.
REQ-019 CHECK (exactly 1 cycle): compare pass_q with key_q by equality of all 2 bits.
- Match: fail_cnt cleared to 0, next state OPEN.
- Mismatch with fail_cnt+1 < MAX_FAIL: fail_cnt incremented, next state FAIL.
- Mismatch with fail_cnt+1 == MAX_FAIL: fail_cnt set to MAX_FAIL, next state LOCKED.
REQ-020 FAIL: err=1 for exactly 1 cycle, then IDLE.
REQ-021 OPEN:
- door_open=1 for exactly OPEN_CYCLES cycles, timed by an 8-bit down-counter loaded on entry; then IDLE.
- Latency: handshake at cycle T produces door_open high from T+2 through T+1+OPEN_CYCLES.
REQ-022 LOCKED:
- locked=1 and alarm=1 for exactly LOCK_CYCLES cycles.
- On exit: fail_cnt cleared to 0, next state IDLE.
REQ-023 key_wr is honoured only in OPEN (authorised session): key_q <= key_in on the next edge. key_wr in any other state is ignored.
REQ-024 A key write during OPEN does not shorten or extend the door_open window. The new key takes effect from the next CHECK.
REQ-025 fail_cnt never wraps or exceeds MAX_FAIL. A successful attempt at any count clears it.
REQ-026 The counter reload on state entry and its decrement are mutually exclusive. The counter is don't-care in IDLE, CHECK and FAIL.

Reset
REQ-027 rst_n low asynchronously forces:
- state=IDLE, key_q=KEY_INIT, fail_cnt=0, pass_q=0, counter=0;
- door_open=0, err=0, locked=0, alarm=0;
- pass_ready=1 while rst_n is low and after release.
REQ-028 Reset asserted mid-OPEN or mid-LOCKED aborts the window immediately. Any key written before reset is lost, and key_q returns to KEY_INIT.
REQ-029 First handshake can occur on the first rising edge after rst_n deasserts.

Verification
REQ-030 Correct pass: reset, pass=2'b10 with valid for 1 cycle at T -> door_open high T+2..T+9 (8 cycles), fail_cnt=0, err never high.
REQ-031 Wrong pass: pass=2'b01 -> err pulses 1 cycle at T+2, fail_cnt=1, door_open stays 0, pass_ready returns 1 at T+3.
REQ-032 Lockout: three wrong attempts -> third gives locked=alarm=1 for 16 cycles with no err pulse. pass_valid during lockout is ignored. Afterwards fail_cnt=0 and a correct pass opens the door.
REQ-033 Failure count cleared: two wrong attempts then a correct one -> fail_cnt 1, 2, 0; door opens; a following wrong attempt gives fail_cnt=1, not a lockout.
REQ-034 Key change: key_wr=1, key_in=2'b11 during OPEN -> later pass 2'b10 fails and pass 2'b11 opens. key_wr=1 in IDLE leaves the key unchanged.
REQ-035 Reset mid-operation: rst_n pulsed low during OPEN cycle 3 -> door_open drops asynchronously, key_q=2'b10, and after release pass 2'b10 opens.
